fetch_stage: RTL



---
 rtl/fetch_stage.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - program counter, PC-tag queue and in-order instruction buffer feeding the decoder
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  input  logic        id_ready
);
  localparam int          CW  = $clog2(DEPTH + 1);
  localparam int          PW  = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] tag_rd_q, tag_rd_d;
  logic [PW-1:0] tag_wr_q, tag_wr_d;
  logic [31:0]   tag_q     [DEPTH];
  logic [31:0]   tag_d     [DEPTH];
  logic [31:0]   buf_pc_q  [DEPTH];
  logic [31:0]   buf_pc_d  [DEPTH];
  logic [31:0]   buf_inst_q[DEPTH];
  logic [31:0]   buf_inst_d[DEPTH];

  logic          pop, accept, push, drop;
  logic [CW:0]   credit_used;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Outputs come straight from buffer registers; imem_rdata never reaches them in the same cycle.
  assign if_valid  = (count_q != '0);
  assign if_inst   = if_valid ? buf_inst_q[rd_ptr_q] : NOP;
  assign if_pc     = if_valid ? buf_pc_q[rd_ptr_q] : 32'h0;
  assign imem_addr = pc_q;

  always_comb begin
    pop         = if_valid & id_ready;
    credit_used = {1'b0, out_q} + {1'b0, count_q} - (CW+1)'(pop);
    imem_req    = !rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    accept      = imem_req & imem_ready;
    drop        = imem_rvalid & (disc_q != '0);
    push        = imem_rvalid & (disc_q == '0) & !redirect_valid;

    pc_d       = pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;
    tag_d      = tag_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
    disc_d     = disc_q;
    out_d      = out_q + CW'(accept) - CW'(imem_rvalid);
    count_d    = count_q + CW'(push) - CW'(pop);

    if (accept) begin
      tag_d[tag_wr_q] = pc_q;
      tag_wr_d        = ptr_inc(tag_wr_q);
      pc_d            = pc_q + 32'd4;
    end
    if (push) begin
      buf_pc_d[wr_ptr_q]   = tag_q[tag_rd_q];
      buf_inst_d[wr_ptr_q] = imem_rdata;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
      tag_rd_d             = ptr_inc(tag_rd_q);
    end
    if (drop) begin
      disc_d = disc_q - CW'(1);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    // Everything still in flight after this cycle belongs to the old path and must be dropped.
    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      tag_rd_d = '0;
      tag_wr_d = '0;
      disc_d   = out_d;
      pc_d     = {redirect_pc[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      out_q    <= '0;
      disc_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      tag_rd_q <= '0;
      tag_wr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      tag_rd_q <= tag_rd_d;
      tag_wr_q <= tag_wr_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q      <= tag_d;
    buf_pc_q   <= buf_pc_d;
    buf_inst_q <= buf_inst_d;
  end

  assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && disc_q == '0 && !redirect_valid && count_q == CW'(DEPTH)));
  assert property (@(posedge clk) disable iff (rst) out_q <= CW'(DEPTH));

endmodule
